// File: rtl/load_store_unit.sv
// RV32I load/store unit: one data-memory access per request over a valid/ready bus.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);
    // state  | meaning
    // IDLE   | waiting for start
    // ACCESS | bus request outstanding, watchdog running
    // DONE   | one-cycle completion pulse and writeback
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_next;

    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT);

    logic [31:0] ea_raw, ea_acc, wdata_next, load_val;
    logic [15:0] rshift;
    logic [3:0]  strb_next;
    logic        size_half, size_word, trap, wd_expire;

    logic [1:0]     lane_q;
    logic [2:0]     funct3_q;
    logic           is_store_q, mis_q, err_q;
    logic [4:0]     rd_q;
    logic [WDW-1:0] wd_cnt;

    always_comb begin
        ea_raw    = base + offset;
        size_half = (funct3[1:0] == 2'b01);
        size_word = funct3[1];
        ea_acc    = ea_raw;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (size_half && ea_raw[0]) || (size_word && (ea_raw[1:0] != 2'b00));
`else
        trap = 1'b0;
        if (size_half) ea_acc[0] = 1'b0;
        if (size_word) ea_acc[1:0] = 2'b00;
`endif
        if (!is_store)     strb_next = 4'b0000;
        else if (size_word) strb_next = 4'b1111;
        else if (size_half) strb_next = 4'b0011 << ea_acc[1:0];
        else               strb_next = 4'b0001 << ea_acc[1:0];
        wdata_next = is_store ? (store_data << {ea_acc[1:0], 3'b000}) : 32'h0;
    end

    always_comb begin
        rshift = 16'(mem_rdata >> {lane_q, 3'b000});
        if (funct3_q[1])
            load_val = mem_rdata;
        else if (funct3_q[0])
            load_val = {{16{rshift[15] & ~funct3_q[2]}}, rshift[15:0]};
        else
            load_val = {{24{rshift[7] & ~funct3_q[2]}}, rshift[7:0]};
    end

    // mem_ready has priority over expiry, so expiry is only meaningful without it
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WDW'(1)) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = trap ? DONE : ACCESS;
            ACCESS:  if (mem_ready || wd_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        wb_en   = done && !is_store_q && !mis_q && !err_q && (rd_q != 5'd0);
        wb_rd   = rd_q;
        bus_err = done && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = done && mis_q;
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            rd_q       <= 5'd0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            wd_cnt     <= '0;
            wb_data    <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'b0000;
        end else begin
            case (state)
                IDLE: if (start) begin
                    lane_q     <= ea_acc[1:0];
                    funct3_q   <= funct3;
                    is_store_q <= is_store;
                    rd_q       <= rd_in;
                    mis_q      <= trap;
                    err_q      <= 1'b0;
                    wd_cnt     <= WD_LOAD;
                    mem_req    <= !trap;
                    mem_we     <= is_store && !trap;
                    mem_addr   <= trap ? 32'h0 : {ea_acc[31:2], 2'b00};
                    mem_wdata  <= trap ? 32'h0 : wdata_next;
                    mem_wstrb  <= trap ? 4'b0000 : strb_next;
                end
                ACCESS: begin
                    if (mem_ready || wd_expire) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'b0000;
                        wd_cnt    <= '0;
                        if (mem_ready && !is_store_q) wb_data <= load_val;
                        if (!mem_ready) err_q <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt - WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// compared against a byte-level reference model of RV32I load/store behaviour.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store, mem_ready;
    logic [2:0]  funct3;
    logic [31:0] base, offset, store_data, mem_rdata;
    logic [4:0]  rd_in;
    logic        mem_req, mem_we, busy, done, wb_en, misaligned, bus_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_wstrb;
    logic [4:0]  wb_rd;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [31:0] last_wb = 32'h0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Gather the selected bytes and extend them as a number.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int lane,
                                               input int size, input bit uns);
        longint v = 0;
        for (int i = 0; i < size; i++)
            v += longint'(rdata[8*(lane+i) +: 8]) << (8*i);
        if (!uns && size < 4 && v >= (longint'(1) << (8*size - 1)))
            v -= longint'(1) << (8*size);
        return v[31:0];
    endfunction

    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] b,
                           input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                           input int waits, input logic [31:0] rdata);
        logic [31:0] ea, acc, exp_addr, exp_wdata;
        logic [3:0]  exp_strb;
        int size, lane, ncyc;
        bit uns, mis, trap, err, exp_wben;
        ea   = b + off;
        size = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        uns  = (f3 == 3'b100 || f3 == 3'b101);
        mis  = (ea % 32'(size)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mis;
        acc  = ea;
`else
        trap = 1'b0;
        acc  = ea - (ea % 32'(size));
`endif
        lane      = int'(acc % 32'd4);
        exp_addr  = acc - 32'(lane);
        exp_strb  = 4'b0000;
        exp_wdata = 32'h0;
        if (st) begin
            for (int i = 0; i < size; i++) exp_strb[lane+i] = 1'b1;
            for (int i = 0; i < 4 - lane; i++) exp_wdata[8*(lane+i) +: 8] = sd[8*i +: 8];
        end
        err      = !trap && (waits >= TO);
        ncyc     = err ? TO : waits + 1;
        exp_wben = !st && !trap && !err && (rd != 5'd0);
        if (!st && !trap && !err) last_wb = model_load(rdata, lane, size, uns);

        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off;
        store_data = sd; rd_in = rd;
        @(posedge clk);
        #1;
        // start stays high while busy and must be ignored; operands are scrambled
        is_store = 1'($urandom); funct3 = 3'($urandom); base = $urandom;
        offset = $urandom; store_data = $urandom; rd_in = 5'($urandom);

        if (!trap) begin
            for (int c = 0; c < ncyc; c++) begin
                @(negedge clk);
                chk("access_req", mem_req, 1);
                chk("access_busy", busy, 1);
                chk("access_done", done, 0);
                chk("access_addr", mem_addr, exp_addr);
                chk("access_we", mem_we, st);
                chk("access_wstrb", mem_wstrb, exp_strb);
                if (st) chk("access_wdata", mem_wdata, exp_wdata);
                mem_ready = (c == waits);
                mem_rdata = (c == waits) ? rdata : $urandom;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_req", mem_req, 0);
        chk("done_wb_en", wb_en, exp_wben);
        chk("done_wb_rd", wb_rd, rd);
        chk("done_wb_data", wb_data, last_wb);
        chk("done_misaligned", misaligned, trap);
        chk("done_bus_err", bus_err, err);
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_wb_en", wb_en, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; base = 32'h0;
        offset = 32'h0; store_data = 32'h0; rd_in = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_bus_err", bus_err, 0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 0, 32'hDEADBEEF);  // LW
        run_txn(0, 3'b000, 32'h200, 32'd3, 32'h0, 5'd6, 0, 32'h80123456);  // LB
        run_txn(0, 3'b100, 32'h200, 32'd3, 32'h0, 5'd7, 1, 32'h80123456);  // LBU
        run_txn(1, 3'b001, 32'h300, 32'd2, 32'h0000ABCD, 5'd9, 3, 32'h0);  // SH, ready on expiry edge
        run_txn(0, 3'b010, 32'h40, 32'd0, 32'h0, 5'd0, 0, 32'h12345678);   // rd = 0
        run_txn(0, 3'b010, 32'h100, 32'd2, 32'h0, 5'd3, 0, 32'hCAFEF00D);  // misaligned LW
        run_txn(0, 3'b001, 32'h201, 32'd0, 32'h0, 5'd4, 0, 32'h0000F0A5);  // misaligned LH
        run_txn(1, 3'b010, 32'h203, 32'd0, 32'h11223344, 5'd1, 0, 32'h0);  // misaligned SW
        run_txn(0, 3'b010, 32'h500, 32'd0, 32'h0, 5'd8, 100, 32'h0);       // watchdog
        run_txn(0, 3'b101, 32'h10, 32'hFFFFFFF2, 32'h0, 5'd2, 2, 32'h9ABC8001); // LHU, wrap
        run_txn(0, 3'b011, 32'h600, 32'd8, 32'h0, 5'd11, 0, 32'h87654321);  // funct3 011 as W
        run_txn(1, 3'b000, 32'h700, 32'd1, 32'hA5A5A5C3, 5'd0, 0, 32'h0);   // SB lane 1

        // reset while a request is outstanding
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h400; offset = 32'h0; rd_in = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_busy", busy, 0);
        last_wb = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        for (int k = 0; k < 40; k++) begin
            bit st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_txn(st, f3, $urandom, 32'($urandom_range(0, 63)) - 32'd32, $urandom,
                    5'($urandom), $urandom_range(0, 5), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
